multicycle_controller: RTL

- Sequences the multicycle RV32I datapath through fetch, decode, execute, memory and writeback states.
- Per state, drives the datapath control signals, the shared instruction/data memory handshake and PC/IR update strobes.
- Sits between the instruction register and the datapath muxes and ALU-op input; it produces control as a registered state sequence rather than a single-cycle decode.

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode, state and control-field encodings
package riscv_pkg;

   // Instruction bits [6:2] of the supported major opcodes
   localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
   localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
   localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
   localparam logic [4:0] OPCODE_STORE   = 5'b01000;
   localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
   localparam logic [4:0] OPCODE_LUI     = 5'b01101;
   localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
   localparam logic [4:0] OPCODE_JALR    = 5'b11001;
   localparam logic [4:0] OPCODE_JAL     = 5'b11011;
   localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SRC_IMM    = 2'b01;
   localparam logic [1:0] PC_SRC_ALU    = 2'b10;

   localparam logic [1:0] ALU_A_RS1     = 2'b00;
   localparam logic [1:0] ALU_A_PC      = 2'b01;
   localparam logic [1:0] ALU_A_ZERO    = 2'b10;

   localparam logic [1:0] ALU_B_RS2     = 2'b00;
   localparam logic [1:0] ALU_B_IMM     = 2'b01;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

   localparam logic [1:0] WB_SEL_ALU    = 2'b00;
   localparam logic [1:0] WB_SEL_MEM    = 2'b01;
   localparam logic [1:0] WB_SEL_PC4    = 2'b10;

   // True for opcodes the datapath can execute (SYSTEM halts, so it is excluded)
   function automatic logic opcode_supported(input logic [4:0] op);
      logic ok;
      case (op)
         OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR,
         OPCODE_ARITH_I, OPCODE_ARITH_R, OPCODE_LUI, OPCODE_AUIPC: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with retired-instruction counter
module multicycle_controller
   import riscv_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [4:0]           opcode,
   input  logic                 mem_ready,
   input  logic                 branch_taken,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_iord,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 reg_write,
   output logic [1:0]           wb_sel,
   output logic                 halted,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_e               state_q, state_d;
   logic [4:0]           opcode_q, opcode_d;
   logic                 illegal_q, illegal_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;

   // State, latched opcode, illegal flag and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   // Next state and per-state control decode; everything is forced low while in reset
   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      illegal_d = illegal_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_iord  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_PLUS4;
      alu_src_a = ALU_A_RS1;
      alu_src_b = ALU_B_RS2;
      alu_op    = ALU_OP_ADD;
      reg_write = 1'b0;
      wb_sel    = WB_SEL_ALU;
      halted    = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_FETCH: begin
               if (run) begin
                  mem_req = 1'b1;
                  if (mem_ready) begin
                     ir_write = 1'b1;
                     state_d  = ST_DECODE;
                  end
               end
            end
            ST_DECODE: begin
               opcode_d = opcode;
               if (opcode == OPCODE_SYSTEM) begin
                  state_d = ST_HALT;
               end else if (!opcode_supported(opcode)) begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_d = ST_WB;
               case (opcode_q)
                  OPCODE_ARITH_R: alu_op = ALU_OP_RFUNCT;
                  OPCODE_ARITH_I: begin
                     alu_src_b = ALU_B_IMM;
                     alu_op    = ALU_OP_IFUNCT;
                  end
                  OPCODE_LUI: begin
                     alu_src_a = ALU_A_ZERO;
                     alu_src_b = ALU_B_IMM;
                  end
                  OPCODE_AUIPC: begin
                     alu_src_a = ALU_A_PC;
                     alu_src_b = ALU_B_IMM;
                  end
                  OPCODE_LOAD, OPCODE_STORE: begin
                     alu_src_b = ALU_B_IMM;
                     state_d   = ST_MEM;
                  end
                  OPCODE_JALR: alu_src_b = ALU_B_IMM;
                  OPCODE_BRANCH: begin
                     alu_op   = ALU_OP_BRANCH;
                     pc_write = 1'b1;
                     pc_src   = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                     state_d  = ST_FETCH;
                  end
                  default: ; // JAL: target comes from pc+imm, ALU idle
               endcase
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               mem_iord = 1'b1;
               mem_we   = (opcode_q == OPCODE_STORE);
               if (mem_ready) begin
                  if (opcode_q == OPCODE_STORE) begin
                     pc_write = 1'b1;
                     state_d  = ST_FETCH;
                  end else begin
                     state_d  = ST_WB;
                  end
               end
            end
            ST_WB: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               state_d   = ST_FETCH;
               case (opcode_q)
                  OPCODE_LOAD: wb_sel = WB_SEL_MEM;
                  OPCODE_JAL: begin
                     wb_sel = WB_SEL_PC4;
                     pc_src = PC_SRC_IMM;
                  end
                  OPCODE_JALR: begin
                     wb_sel = WB_SEL_PC4;
                     pc_src = PC_SRC_ALU;
                  end
                  default: ;
               endcase
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
         endcase
      end
   end

   // Every PC update is one retired instruction; the counter wraps naturally
   always_comb begin
      instret_d = instret_q;
      if (pc_write) instret_d = instret_q + INSTRET_W'(1);
   end

   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule
